// File: rtl/skew_rf.sv
// Operand register file for the systolic array: DEPTH rows of N X-lanes and N W-lanes,
// streamed out diagonally skewed (lane k delayed k cycles) so the PE array edges are fed directly.

module skew_lane #(
   parameter int DATA_W = 16,
   parameter int DELAY  = 0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              en,
   input  logic              in_vld,
   input  logic [DATA_W-1:0] in_x,
   input  logic [DATA_W-1:0] in_w,
   output logic              out_vld,
   output logic [DATA_W-1:0] out_x,
   output logic [DATA_W-1:0] out_w
);
   logic [DELAY:0]             vld_pipe;
   logic [DELAY:0][DATA_W-1:0] x_pipe;
   logic [DELAY:0][DATA_W-1:0] w_pipe;

   // Stage 0 is the output register for lane 0; lane k adds k more stages.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         vld_pipe <= '0;
         x_pipe   <= '0;
         w_pipe   <= '0;
      end else if (en) begin
         vld_pipe[0] <= in_vld;
         x_pipe[0]   <= in_vld ? in_x : '0;
         w_pipe[0]   <= in_vld ? in_w : '0;
         for (int s = 1; s <= DELAY; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            x_pipe[s]   <= x_pipe[s-1];
            w_pipe[s]   <= w_pipe[s-1];
         end
      end
   end

   assign out_vld = vld_pipe[DELAY];
   assign out_x   = x_pipe[DELAY];
   assign out_w   = w_pipe[DELAY];
endmodule

module skew_rf #(
   parameter int DATA_W = 16,
   parameter int N      = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                RF_EN,
   input  logic                WRITE,
   input  logic [ADDR_W-1:0]   IDX,
   input  logic [N*DATA_W-1:0] X_IN,
   input  logic [N*DATA_W-1:0] W_IN,
   input  logic                START,
   input  logic [ADDR_W:0]     LEN,
   output logic [N*DATA_W-1:0] X_OUT,
   output logic [N*DATA_W-1:0] W_OUT,
   output logic [N-1:0]        OUT_VALID,
   output logic                BUSY,
   output logic                DONE
);
   localparam int              DCNT_W  = $clog2(N) + 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

   state_t              state, state_n;
   logic [ADDR_W:0]     cnt, cnt_n, len_q, len_n, len_eff;
   logic [DCNT_W-1:0]   dcnt, dcnt_n;
   logic                busy_n, done_n, rd_vld;

   logic [N-1:0][DATA_W-1:0] mem_x [DEPTH];
   logic [N-1:0][DATA_W-1:0] mem_w [DEPTH];

   logic                     wb_vld;
   logic [ADDR_W-1:0]        wb_idx;
   logic [N-1:0][DATA_W-1:0] wb_x, wb_w;

   logic [ADDR_W-1:0]        rd_idx;
   logic                     fwd;
   logic [N-1:0][DATA_W-1:0] rd_x, rd_w;

   assign len_eff = (LEN > DEPTH_L) ? DEPTH_L : LEN;

   // Write buffer: capture now, commit on the next enabled edge.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wb_vld <= 1'b0;
         wb_idx <= '0;
         wb_x   <= '0;
         wb_w   <= '0;
      end else if (RF_EN) begin
         wb_vld <= WRITE && !BUSY;
         if (WRITE && !BUSY) begin
            wb_idx <= IDX;
            wb_x   <= X_IN;
            wb_w   <= W_IN;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RF_EN && wb_vld) begin
         mem_x[wb_idx] <= wb_x;
         mem_w[wb_idx] <= wb_w;
      end
   end

   // A write captured on the START edge is still in the buffer when row 0 is read.
   assign rd_idx = cnt[ADDR_W-1:0];
   assign fwd    = wb_vld && (wb_idx == rd_idx);
   assign rd_x   = fwd ? wb_x : mem_x[rd_idx];
   assign rd_w   = fwd ? wb_w : mem_w[rd_idx];

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      len_n   = len_q;
      dcnt_n  = dcnt;
      busy_n  = BUSY;
      done_n  = 1'b0;
      rd_vld  = 1'b0;
      case (state)
         IDLE: begin
            if (START) begin
               busy_n = 1'b1;
               cnt_n  = '0;
               len_n  = len_eff;
               if (len_eff == '0) begin
                  state_n = DRAIN;
                  dcnt_n  = '0;
               end else begin
                  state_n = STREAM;
               end
            end
         end
         STREAM: begin
            rd_vld = 1'b1;
            cnt_n  = cnt + 1'b1;
            if (cnt_n == len_q) begin
               state_n = DRAIN;
               dcnt_n  = DCNT_W'(N-1);
            end
         end
         DRAIN: begin
            if (dcnt == '0) begin
               state_n = IDLE;
               busy_n  = 1'b0;
               done_n  = 1'b1;
            end else begin
               dcnt_n = dcnt - 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         cnt   <= '0;
         len_q <= '0;
         dcnt  <= '0;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
      end else if (RF_EN) begin
         state <= state_n;
         cnt   <= cnt_n;
         len_q <= len_n;
         dcnt  <= dcnt_n;
         BUSY  <= busy_n;
         DONE  <= done_n;
      end
   end

   generate
      for (genvar k = 0; k < N; k++) begin : g_lane
         skew_lane #(.DATA_W(DATA_W), .DELAY(k)) u_lane (
            .CLK     (CLK),
            .RST     (RST),
            .en      (RF_EN),
            .in_vld  (rd_vld),
            .in_x    (rd_x[k]),
            .in_w    (rd_w[k]),
            .out_vld (OUT_VALID[k]),
            .out_x   (X_OUT[k*DATA_W +: DATA_W]),
            .out_w   (W_OUT[k*DATA_W +: DATA_W])
         );
      end
   endgenerate
endmodule

// File: tb/tb_skew_rf.sv
// Randomized bench for skew_rf against a row-snapshot reference model of the skewed stream.

module tb_skew_rf;
   localparam int DATA_W = 16;
   localparam int N      = 8;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int NW     = N * DATA_W;

   logic              CLK = 1'b0;
   logic              RST = 1'b0;
   logic              RF_EN, WRITE, START;
   logic [ADDR_W-1:0] IDX;
   logic [NW-1:0]     X_IN, W_IN;
   logic [ADDR_W:0]   LEN;
   logic [NW-1:0]     X_OUT, W_OUT;
   logic [N-1:0]      OUT_VALID;
   logic              BUSY, DONE;

   always #5 CLK = ~CLK;

   skew_rf #(.DATA_W(DATA_W), .N(N), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST), .RF_EN(RF_EN), .WRITE(WRITE), .IDX(IDX),
      .X_IN(X_IN), .W_IN(W_IN), .START(START), .LEN(LEN),
      .X_OUT(X_OUT), .W_OUT(W_OUT), .OUT_VALID(OUT_VALID), .BUSY(BUSY), .DONE(DONE)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference: memory as seen by writes, plus a snapshot taken when a stream starts.
   logic [DATA_W-1:0] m_x [DEPTH][N];
   logic [DATA_W-1:0] m_w [DEPTH][N];
   logic [DATA_W-1:0] s_x [DEPTH][N];
   logic [DATA_W-1:0] s_w [DEPTH][N];
   bit m_busy = 0, m_act = 0, m_done = 0;
   int m_c = 0, m_leff = 0;

   task automatic chk(input string tag, input logic [NW-1:0] got, input logic [NW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_act = 0; m_done = 0;
   endtask

   task automatic model_edge();
      bit old;
      if (RST) begin
         model_reset();
      end else if (RF_EN) begin
         old    = m_busy;
         m_done = 0;
         if (m_busy) m_c++;
         if (!old && WRITE)
            for (int k = 0; k < N; k++) begin
               m_x[IDX][k] = X_IN[k*DATA_W +: DATA_W];
               m_w[IDX][k] = W_IN[k*DATA_W +: DATA_W];
            end
         if (!old && START) begin
            m_busy = 1; m_act = 1; m_c = 0;
            m_leff = (int'(LEN) > DEPTH) ? DEPTH : int'(LEN);
            s_x = m_x;
            s_w = m_w;
         end else if (old && m_c == ((m_leff == 0) ? 1 : m_leff + N)) begin
            m_busy = 0; m_act = 0; m_done = 1;
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [NW-1:0] ex, ew;
      logic [N-1:0]  ev;
      ex = '0; ew = '0; ev = '0;
      if (m_act)
         for (int k = 0; k < N; k++) begin
            int r;
            r = m_c - 1 - k;
            if (r >= 0 && r < m_leff) begin
               ev[k] = 1'b1;
               ex[k*DATA_W +: DATA_W] = s_x[r][k];
               ew[k*DATA_W +: DATA_W] = s_w[r][k];
            end
         end
      chk({tag, ".x"},     X_OUT,     ex);
      chk({tag, ".w"},     W_OUT,     ew);
      chk({tag, ".valid"}, NW'(OUT_VALID), NW'(ev));
      chk({tag, ".busy"},  NW'(BUSY), NW'(m_busy));
      chk({tag, ".done"},  NW'(DONE), NW'(m_done));
   endtask

   task automatic tick(input string tag);
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      check_outputs(tag);
   endtask

   task automatic write_row(input int idx, input logic [NW-1:0] x, input logic [NW-1:0] w);
      RF_EN = 1; WRITE = 1; IDX = ADDR_W'(idx); X_IN = x; W_IN = w;
      tick("wr");
      WRITE = 0;
   endtask

   task automatic start_stream(input string tag, input int len);
      RF_EN = 1; START = 1; LEN = (ADDR_W+1)'(len);
      tick(tag);
      START = 0;
   endtask

   task automatic wait_done(input string tag, input int pct_freeze, input bit junk, output int ticks);
      ticks = 0;
      while (!DONE && ticks < 200) begin
         RF_EN = ($urandom_range(99) >= pct_freeze);
         if (junk) begin
            WRITE = ($urandom_range(3) == 0);
            START = ($urandom_range(3) == 0);
            IDX   = ADDR_W'($urandom);
            LEN   = (ADDR_W+1)'($urandom_range(1, 20));
            X_IN  = {$urandom, $urandom, $urandom, $urandom};
            W_IN  = {$urandom, $urandom, $urandom, $urandom};
         end
         tick(tag);
         ticks++;
      end
      RF_EN = 1; WRITE = 0; START = 0;
      if (!DONE) chk({tag, ".timeout"}, 0, 1);
   endtask

   function automatic logic [NW-1:0] splat(input logic [DATA_W-1:0] v);
      logic [NW-1:0] r;
      for (int k = 0; k < N; k++) r[k*DATA_W +: DATA_W] = v;
      return r;
   endfunction

   function automatic logic [NW-1:0] rnd_row();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      int t;
      RF_EN = 0; WRITE = 0; START = 0; IDX = '0; X_IN = '0; W_IN = '0; LEN = '0;
      #1 RST = 1;
      model_reset();
      #1 check_outputs("reset");
      tick("reset"); tick("reset");
      RST = 0;
      RF_EN = 1;
      tick("idle");

      // Fill: every lane of row i holds i
      for (int i = 0; i < DEPTH; i++) write_row(i, splat(DATA_W'(i)), splat(DATA_W'(i)));
      start_stream("fill", 16);
      wait_done("fill", 0, 0, t);
      chk("fill.lat", NW'(t), NW'(24));

      // Forwarding: row 3 written the edge before START, row 0 on the START edge
      write_row(3, splat(16'hABCD), rnd_row());
      WRITE = 1; IDX = '0; X_IN = rnd_row(); W_IN = rnd_row();
      start_stream("fwd", 4);
      WRITE = 0;
      for (int i = 0; i < 4; i++) tick("fwd");
      chk("fwd.lane0", NW'(X_OUT[DATA_W-1:0]), NW'(16'hABCD));
      wait_done("fwd", 0, 0, t);
      chk("fwd.lat", NW'(t + 4), NW'(12));

      // Enable freeze mid-STREAM stretches the stream by exactly the frozen cycles
      start_stream("frz", 16);
      for (int i = 0; i < 5; i++) tick("frz");
      RF_EN = 0;
      for (int i = 0; i < 3; i++) tick("frz.hold");
      RF_EN = 1;
      wait_done("frz", 0, 0, t);
      chk("frz.lat", NW'(t + 8), NW'(27));

      // LEN boundaries
      start_stream("len0", 0);
      wait_done("len0", 0, 0, t);
      chk("len0.lat", NW'(t), NW'(1));
      start_stream("len20", 20);
      wait_done("len20", 0, 0, t);
      chk("len20.lat", NW'(t), NW'(24));

      // WRITE and START while busy are ignored
      start_stream("ign", 8);
      tick("ign"); tick("ign");
      WRITE = 1; START = 1; LEN = 3; IDX = 2; X_IN = rnd_row(); W_IN = rnd_row();
      tick("ign");
      WRITE = 0; START = 0;
      wait_done("ign", 0, 0, t);
      chk("ign.lat", NW'(t + 3), NW'(16));
      start_stream("ign.verify", 16);
      wait_done("ign.verify", 0, 0, t);

      // Randomized traffic with freezes and junk commands during streams
      for (int it = 0; it < 40; it++) begin
         int nw;
         nw = $urandom_range(0, 4);
         for (int j = 0; j < nw; j++) begin
            RF_EN = ($urandom_range(9) != 0);
            WRITE = 1; IDX = ADDR_W'($urandom); X_IN = rnd_row(); W_IN = rnd_row();
            tick("rnd.wr");
         end
         WRITE = ($urandom_range(1) == 0); IDX = ADDR_W'($urandom); X_IN = rnd_row(); W_IN = rnd_row();
         start_stream("rnd", $urandom_range(0, 20));
         WRITE = 0;
         wait_done("rnd", 15, 1, t);
         if ($urandom_range(2) == 0) tick("rnd.gap");
      end

      // Reset in DRAIN aborts without DONE; storage survives
      write_row(0, rnd_row(), rnd_row());
      write_row(1, rnd_row(), rnd_row());
      start_stream("rstd", 2);
      for (int i = 0; i < 4; i++) tick("rstd");
      RST = 1;
      model_reset();
      #1 check_outputs("rstd.async");
      tick("rstd.hold"); tick("rstd.hold");
      RST = 0;
      start_stream("rstd.after", 2);
      wait_done("rstd.after", 0, 0, t);
      chk("rstd.lat", NW'(t), NW'(10));
      tick("end");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
